// File: rtl/sd_spi_cmd_host.sv
// Host-side SPI-mode (mode 0) SD command engine: sends one 48-bit command frame,
// polls 0xFF filler bytes for the R1 response, then clocks one trailing Nrc byte.
module sd_spi_cmd_host #(
  parameter int CLK_DIV      = 2,
  parameter int RESP_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] arg,
  input  logic [6:0]  crc,
  output logic        busy,
  output logic        done,
  output logic [7:0]  resp,
  output logic        timeout,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CMD, RESP, TAIL} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [5:0]      bit_q, bit_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic [47:0]     tx_q, tx_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      resp_q, resp_d;
  logic            timeout_q, timeout_d;
  logic            miso_q;
  logic            cs_n_q, cs_n_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic tick, fall, smp, accept;

  // sclk_q doubles as the phase register: a divider wrap while high ends a bit.
  assign tick   = (state_q != IDLE) && (div_q == DW'(CLK_DIV - 1));
  assign fall   = tick && sclk_q;
  assign smp    = (state_q == RESP) && sclk_q && (div_q == '0);
  // The done cycle already shows IDLE, so a restart is held off until the cycle after.
  assign accept = (state_q == IDLE) && start && !done_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      tx_q      <= '1;
      rx_q      <= 8'hFF;
      resp_q    <= 8'hFF;
      timeout_q <= 1'b0;
      miso_q    <= 1'b1;
      cs_n_q    <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
      miso_q    <= miso;
      cs_n_q    <= cs_n_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;

    if (state_q != IDLE) div_d = tick ? '0 : div_q + 1'b1;
    if (smp)             rx_d  = {rx_q[6:0], miso_q};
    if (fall) begin
      tx_d  = {tx_q[46:0], 1'b1};
      bit_d = bit_q + 6'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = CMD;
          div_d     = '0;
          bit_d     = '0;
          byte_d    = '0;
          tx_d      = {2'b01, cmd_index, arg, crc, 1'b1};
          rx_d      = 8'hFF;
          resp_d    = 8'hFF;
          timeout_d = 1'b0;
        end
      end
      CMD: begin
        if (fall && bit_q == 6'd47) begin
          state_d = RESP;
          bit_d   = '0;
          byte_d  = BW'(1);
        end
      end
      RESP: begin
        // rx_d already holds the last sampled bit when CLK_DIV is 1.
        if (fall && bit_q == 6'd7) begin
          bit_d = '0;
          if (!rx_d[7]) begin
            resp_d  = rx_d;
            state_d = TAIL;
          end else if (byte_q == BW'(RESP_TIMEOUT)) begin
            timeout_d = 1'b1;
            state_d   = TAIL;
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end
      end
      TAIL: begin
        if (fall && bit_q == 6'd7) begin
          state_d = IDLE;
          bit_d   = '0;
          byte_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cs_n_d = (state_d == IDLE);
    busy_d = (state_d != IDLE);
    done_d = (state_q == TAIL) && (state_d == IDLE);
    sclk_d = 1'b0;
    if (state_d != IDLE) sclk_d = tick ? ~sclk_q : sclk_q;
    mosi_d = (state_d == IDLE) ? 1'b1 : tx_d[47];
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign resp    = resp_q;
  assign timeout = timeout_q;
  assign cs_n    = cs_n_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_sd_spi_cmd_host.sv
// Self-checking bench for sd_spi_cmd_host: a byte-level SD card model answers on miso,
// and each transfer is checked cycle by cycle against timing derived from the frame rules.
module tb_sd_spi_cmd_host;

  localparam int RT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1;
  logic [5:0]  cmd_index;
  logic [31:0] arg;
  logic [6:0]  crc;
  logic        miso;

  logic        busy0, done0, timeout0, cs_n0, sclk0, mosi0;
  logic        busy1, done1, timeout1, cs_n1, sclk1, mosi1;
  logic [7:0]  resp0, resp1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sd_spi_cmd_host #(.CLK_DIV(2), .RESP_TIMEOUT(RT)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cmd_index(cmd_index), .arg(arg), .crc(crc),
    .busy(busy0), .done(done0), .resp(resp0), .timeout(timeout0),
    .cs_n(cs_n0), .sclk(sclk0), .mosi(mosi0), .miso(miso)
  );

  sd_spi_cmd_host #(.CLK_DIV(1), .RESP_TIMEOUT(RT)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cmd_index(cmd_index), .arg(arg), .crc(crc),
    .busy(busy1), .done(done1), .resp(resp1), .timeout(timeout1),
    .cs_n(cs_n1), .sclk(sclk1), .mosi(mosi1), .miso(miso)
  );

  // The card model and the checks follow whichever DUT is currently selected.
  logic card_sel = 1'b0;
  wire        o_sclk    = card_sel ? sclk1    : sclk0;
  wire        o_mosi    = card_sel ? mosi1    : mosi0;
  wire        o_cs_n    = card_sel ? cs_n1    : cs_n0;
  wire        o_busy    = card_sel ? busy1    : busy0;
  wire        o_done    = card_sel ? done1    : done0;
  wire        o_timeout = card_sel ? timeout1 : timeout0;
  wire [7:0]  o_resp    = card_sel ? resp1    : resp0;

  int          card_cnt = 0;
  logic [47:0] card_frame = '0;
  int          card_rbyte = 0;
  logic [7:0]  card_rval = 8'hFF;

  // Bit i of the card's output stream: 1s during the command, R1 in poll byte card_rbyte.
  function automatic logic card_bit(input int i);
    int p;
    if (i < 48) return 1'b1;
    p = i - 48;
    if (p / 8 + 1 == card_rbyte) return card_rval[3'(7 - p % 8)];
    return 1'b1;
  endfunction

  initial begin
    miso = 1'b1;
    forever begin
      @(posedge o_sclk);
      if (card_cnt < 48) card_frame = {card_frame[46:0], o_mosi};
      card_cnt = card_cnt + 1;
      @(negedge o_sclk);
      miso = card_bit(card_cnt);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cs_n"},    o_cs_n,    1'b1);
    check({tag, "_sclk"},    o_sclk,    1'b0);
    check({tag, "_mosi"},    o_mosi,    1'b1);
    check({tag, "_busy"},    o_busy,    1'b0);
  endtask

  // One command transfer on DUT sel. rbyte is the poll byte the card answers in
  // (0 or out of range: never). abort_cyc > 0 pulls rst_n low in that cycle.
  task automatic do_xfer(input bit sel, input logic [5:0] c, input logic [31:0] a,
                         input logic [6:0] r, input int rbyte, input logic [7:0] rval,
                         input bit disturb, input int abort_cyc);
    logic [47:0] exp_frame;
    logic [7:0]  exp_resp;
    bit          found;
    int          t, k, exp_done, done_cyc, n, extra;
    t         = sel ? 2 : 4;
    found     = (rbyte >= 1) && (rbyte <= RT) && !rval[7];
    k         = found ? rbyte : RT;
    exp_resp  = found ? rval : 8'hFF;
    exp_done  = 1 + (56 + 8 * k) * t;
    exp_frame = {2'b01, c, a, r, 1'b1};

    card_sel   = sel;
    card_cnt   = 0;
    card_frame = '0;
    card_rbyte = rbyte;
    card_rval  = rval;

    @(negedge clk);
    cmd_index = c;
    arg       = a;
    crc       = r;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;

    check("c1_busy", o_busy, 1'b1);
    check("c1_cs_n", o_cs_n, 1'b0);
    check("c1_sclk", o_sclk, 1'b0);
    check("c1_mosi", o_mosi, exp_frame[47]);

    done_cyc = -1;
    for (int cyc = 1; cyc <= exp_done + 40; cyc++) begin
      if (o_done) begin
        done_cyc = cyc;
        break;
      end
      if (abort_cyc > 0 && cyc == abort_cyc) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        check("async_rst_done",    o_done,    1'b0);
        check("async_rst_resp",    o_resp,    8'hFF);
        check("async_rst_timeout", o_timeout, 1'b0);
        extra = 0;
        repeat (3) begin
          @(negedge clk);
          if (o_done || o_busy) extra++;
        end
        check("rst_no_activity", extra, 0);
        rst_n = 1'b1;
        return;
      end
      n = (cyc - 1) / t;
      check("sclk_phase", o_sclk, ((cyc - 1) % t) >= (t / 2));
      check("mosi_bit",   o_mosi, (n < 48) ? exp_frame[47 - n] : 1'b1);
      check("cs_n_low",   o_cs_n, 1'b0);
      check("busy_high",  o_busy, 1'b1);
      if (disturb && cyc == 40) begin
        arg       = ~a;
        cmd_index = ~c;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
      end else begin
        start0 = 1'b0;
        start1 = 1'b0;
      end
      @(negedge clk);
    end

    check("done_cycle", done_cyc, exp_done);
    check_idle_outputs("done");
    check("resp",    o_resp,    exp_resp);
    check("timeout", o_timeout, !found);
    check("frame",   card_frame, exp_frame);

    extra = 0;
    repeat (20 * t) begin
      @(negedge clk);
      if (o_done || o_busy) extra++;
    end
    check("no_second_xfer", extra, 0);
    check("resp_held",    o_resp,    exp_resp);
    check("timeout_held", o_timeout, !found);
  endtask

  initial begin
    logic [5:0]  rc;
    logic [31:0] ra;
    logic [6:0]  rr;
    logic [7:0]  rv;
    int          rb;
    bit          rs;

    rst_n     = 1'b0;
    start0    = 1'b0;
    start1    = 1'b0;
    cmd_index = '0;
    arg       = '0;
    crc       = '0;
    repeat (3) @(negedge clk);

    check_idle_outputs("reset");
    check("reset_done",    o_done,    1'b0);
    check("reset_resp",    o_resp,    8'hFF);
    check("reset_timeout", o_timeout, 1'b0);
    check("reset1_cs_n",   cs_n1,     1'b1);
    check("reset1_busy",   busy1,     1'b0);
    check("reset1_resp",   resp1,     8'hFF);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("post_reset");

    // CMD0 answered in the first poll byte: 40 00 00 00 00 95, done at 257.
    do_xfer(1'b0, 6'd0, 32'h0, 7'h4A, 1, 8'h01, 1'b0, 0);
    // CMD8 answered in poll byte 3: 48 00 00 01 AA 87, done at 321.
    do_xfer(1'b0, 6'd8, 32'h0000_01AA, 7'h43, 3, 8'h01, 1'b0, 0);
    // Card silent: timeout after 8 poll bytes, done at 481.
    do_xfer(1'b0, 6'd55, 32'h0, 7'h32, 0, 8'hFF, 1'b0, 0);
    // A second start mid-CMD with a different argument must be ignored.
    do_xfer(1'b0, 6'd17, 32'hDEAD_BEEF, 7'h15, 2, 8'h00, 1'b1, 0);
    // Reset during RESP, then a clean CMD0.
    do_xfer(1'b0, 6'd0, 32'h0, 7'h4A, 1, 8'h01, 1'b0, 200);
    repeat (2) @(negedge clk);
    do_xfer(1'b0, 6'd0, 32'h0, 7'h4A, 1, 8'h01, 1'b0, 0);
    // Fastest divider: 0x05 in poll byte 2.
    do_xfer(1'b1, 6'd41, 32'h4000_0000, 7'h77, 2, 8'h05, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      rs = 1'($urandom_range(0, 1));
      rc = 6'($urandom);
      ra = $urandom;
      rr = 7'($urandom);
      rb = int'($urandom_range(0, RT + 1));
      rv = 8'($urandom);
      if ($urandom_range(0, 3) != 0) rv[7] = 1'b0;
      do_xfer(rs, rc, ra, rr, rb, rv, 1'($urandom_range(0, 1)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_spi_cmd_host.md
# sd_spi_cmd_host

Host-side SPI-mode SD command engine: the initiator for the card-side responder. It serialises one 48-bit SD command frame (SPI mode 0) on `mosi`/`sclk` with `cs_n` asserted. It then clocks out 0xFF filler bytes while polling `miso` for the R1 response byte, and reports the R1 value or a timeout. It sits between the host controller's command sequencer (CMD0/CMD8/ACMD41 init flow) and the SD card pins.

## Interface
Parameters:
- `CLK_DIV`, 2, `clk` cycles per `sclk` half-period; must be ≥1.
- `RESP_TIMEOUT`, 8, maximum filler bytes polled for R1 (Ncr limit); must be ≥1.

Ports:
- `clk`  in  1  system clock; the block uses this one clock only.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request pulse; accepted only in IDLE.
- `cmd_index`  in  6  command index; captured on accept.
- `arg`  in  32  command argument; captured on accept.
- `crc`  in  7  CRC7 of the frame, precomputed by the sequencer; captured on accept.
- `busy`  out  1  high from the cycle after accept until `done`.
- `done`  out  1  one-cycle completion pulse.
- `resp`  out  8  R1 byte. Valid from `done`, held until the next accept.
- `timeout`  out  1  no R1 seen within `RESP_TIMEOUT` bytes. Valid from `done`, held until the next accept.
- `cs_n`  out  1  card select, active-low.
- `sclk`  out  1  SPI clock, idle low.
- `mosi`  out  1  host-to-card data, idle high.
- `miso`  in  1  card-to-host data; the block registers it internally.

## Operation
- Frame is 6 bytes, transmitted MSB first:
  - byte 0 = {2'b01, `cmd_index`}
  - bytes 1–4 = `arg[31:24]`, `arg[23:16]`, `arg[15:8]`, `arg[7:0]`
  - byte 5 = {`crc`, 1'b1}
  - Example: CMD0 with arg 0 and crc 7'h4A gives 40 00 00 00 00 95.
- SPI mode 0:
  - `mosi` changes only while `sclk` is low, at the start of each bit period.
  - `miso` is sampled in the `clk` cycle in which `sclk` rises.
- FSM states: IDLE → CMD → RESP → TAIL → IDLE.
  - **IDLE:** `cs_n`=1, `sclk`=0, `mosi`=1. When `start`=1, capture the inputs, clear `timeout`, set `resp`=8'hFF, and go to CMD.
  - **CMD:** shift 48 bits. After bit 0 completes, go to RESP.
  - **RESP:** transmit 8'hFF byte-wise and assemble 8 sampled `miso` bits per byte.
    - At each byte boundary, if the assembled byte has MSB=0, latch it into `resp` and go to TAIL.
    - Else, if this was byte number `RESP_TIMEOUT`, set `timeout`=1, leave `resp`=8'hFF, and go to TAIL.
  - **TAIL:** one 8'hFF byte (8 clocks, Nrc). At its end, `cs_n`=1, `done`=1, and return to IDLE.
- R1 detection is byte-aligned to the frame end; bit-level hunting is not supported.
- `start` while `busy`=1 is ignored; the captured inputs are not disturbed.
- Counters:
  - bit counter 0..47, 6 bits
  - byte counter 1..`RESP_TIMEOUT`, width $clog2(`RESP_TIMEOUT`+1)
  - divider counter 0..`CLK_DIV`-1

## Timing
- Reset values: `cs_n`=1, `sclk`=0, `mosi`=1, `busy`=0, `done`=0, `resp`=8'hFF, `timeout`=0. FSM=IDLE, all counters 0.
- Let T=2·`CLK_DIV` (bit period) and accept cycle = 0.
  - Cycle 1: `busy`=1, `cs_n`=0, `mosi`=frame bit 47, `sclk`=0.
  - Bit n (n=0 first) occupies cycles 1+n·T … (n+1)·T.
  - `sclk` rises at 1+n·T+`CLK_DIV` and falls at 1+(n+1)·T.
- With R1 found in poll byte k (1 ≤ k ≤ `RESP_TIMEOUT`), `done`=1 and `cs_n`=1 at cycle 1+(56+8k)·T. `busy`=0 in that cycle; the FSM is in IDLE on the next cycle.
- On timeout, `done` is at 1+(56+8·`RESP_TIMEOUT`)·T.
- A back-to-back `start` is accepted in the cycle after `done` at the earliest.
- Reset mid-transfer: all outputs return to reset values immediately (asynchronous). No `done` pulse. The next transfer needs a fresh `start`.

## Test plan
- Bench card model returns 0x01 on CMD0. `CLK_DIV`=2, cmd 0, arg 0, crc 7'h4A, card responds in byte 1 → bench captures 40 00 00 00 00 95 on `mosi`; `resp`=8'h01, `timeout`=0, `done` at cycle 1+64·4=257.
- CMD8 with arg 32'h000001AA, crc 7'h43, card delays R1 0x01 to poll byte 3 → frame 48 00 00 01 AA 87; `done` at cycle 1+80·4=321.
- `miso` held high, `RESP_TIMEOUT`=8 → `timeout`=1, `resp`=8'hFF, `done` at 1+120·4=481. `cs_n` is low throughout until `done`.
- `start` pulsed again mid-CMD with different arg → frame unchanged, one `done` only.
- `rst_n` driven low during RESP → `cs_n`=1, `sclk`=0, `mosi`=1, `busy`=0 without waiting for a clock edge. A following CMD0 completes normally with `resp`=8'h01.
- `CLK_DIV`=1, card returns 0x05 in byte 2 → `resp`=8'h05; every `sclk` high/low phase is exactly 1 cycle; `mosi` is stable across every rising edge.
